// File: rtl/rns_pkg.sv
// Shared helpers and constants for the residue-number-system forward converter.
package rns_pkg;

    localparam int MOD_17 = 17;
    localparam int HP_4   = 4;
    localparam int MOD_13 = 13;
    localparam int HP_6   = 6;
    localparam int MOD_11 = 11;
    localparam int HP_5   = 5;

    function automatic int clog2(input int v);
        int r;
        int p;
        r = 0;
        p = 1;
        while (p < v) begin
            p = p * 2;
            r = r + 1;
        end
        return r;
    endfunction

    // True when 2^hp == -1 (mod m) for an odd modulus above 2.
    function automatic bit hp_ok(input int m, input int hp);
        int r;
        r = 1;
        for (int i = 0; i < hp; i++) r = (r * 2) % m;
        return (m > 2) && (m % 2 == 1) && (r == m - 1);
    endfunction

    function automatic int fold_offset(input int ng);
        return 2 * (ng / 2);
    endfunction

    function automatic int corr_kb(input int m, input int hp);
        int kb;
        kb = -1;
        for (int k = 0; k < 31; k++) begin
            if (kb < 0 && ((longint'(m) << (k + 1)) > (longint'(1) << (hp + 1))))
                kb = k;
        end
        return kb;
    endfunction

endpackage

// File: rtl/hp_fold.sv
// Half-period fold: alternating-sign sum of HP-bit groups, complement form.
module hp_fold
    import rns_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int HP    = 4,
    parameter int OUT_W = HP + clog2((IN_W + HP - 1) / HP + 1) + 1
) (
    input  logic [IN_W-1:0]  x,
    output logic [OUT_W-1:0] y
);

    localparam int NG   = (IN_W + HP - 1) / HP;
    localparam int XW   = NG * HP;
    localparam int OFFS = fold_offset(NG);

    logic [XW-1:0] x_ext;
    logic [HP-1:0] g;
    logic [HP-1:0] gn;

    always_comb begin
        x_ext = XW'(x);
        y     = OUT_W'(OFFS);
        g     = '0;
        gn    = '0;
        for (int i = 0; i < NG; i++) begin
            g  = x_ext[i*HP +: HP];
            gn = ~g;
            if (i % 2 == 1) y = y + OUT_W'(gn);
            else            y = y + OUT_W'(g);
        end
    end

endmodule

// File: rtl/rns_residue_hp_pipe.sv
// Three-stage X mod MOD generator: two half-period folds, then exact
// restoring correction, with valid/ready flow control and a tag sideband.
module rns_residue_hp_pipe
    import rns_pkg::*;
#(
    parameter int N_W   = 16,
    parameter int MOD   = 17,
    parameter int HP    = 4,
    parameter int TAG_W = 4,
    localparam int R_W  = clog2(MOD)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_W-1:0]   in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [R_W-1:0]   out_res,
    output logic [TAG_W-1:0] out_tag
);

    localparam int NG   = (N_W + HP - 1) / HP;
    localparam int S1_W = HP + clog2(NG + 1) + 1;
    localparam int S2_W = HP + 2;
    localparam int KB   = corr_kb(MOD, HP);

    if (!hp_ok(MOD, HP)) begin : g_bad_hp
        $fatal(1, "HP is not a half period of MOD");
    end
    if (S1_W > 2 * HP) begin : g_bad_w
        $fatal(1, "first fold too wide for a two-group second fold");
    end

    logic             v1, v2, v3;
    logic             ld1, ld2, ld3;
    logic [S1_W-1:0]  s1_d, s1_q;
    logic [S2_W-1:0]  s2_d, s2_q;
    logic [S2_W-1:0]  cv;
    logic [R_W-1:0]   r3_d, r3;
    logic [TAG_W-1:0] t1, t2, t3;

    hp_fold #(.IN_W(N_W), .HP(HP), .OUT_W(S1_W)) u_fold1 (
        .x (in_data),
        .y (s1_d)
    );

    hp_fold #(.IN_W(S1_W), .HP(HP), .OUT_W(S2_W)) u_fold2 (
        .x (s1_q),
        .y (s2_d)
    );

    // Every MOD*2^k used here fits in S2_W bits since MOD <= 2^HP + 1.
    always_comb begin
        cv = s2_q;
        for (int k = KB; k >= 0; k--) begin
            if (cv >= S2_W'(MOD << k)) cv = cv - S2_W'(MOD << k);
        end
        r3_d = R_W'(cv);
    end

    assign ld3      = !v3 || out_ready;
    assign ld2      = !v2 || ld3;
    assign ld1      = !v1 || ld2;
    assign in_ready = ld1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            v2   <= 1'b0;
            v3   <= 1'b0;
            s1_q <= '0;
            s2_q <= '0;
            r3   <= '0;
            t1   <= '0;
            t2   <= '0;
            t3   <= '0;
        end else begin
            if (ld1) begin
                v1 <= in_valid;
                if (in_valid) begin
                    s1_q <= s1_d;
                    t1   <= in_tag;
                end
            end
            if (ld2) begin
                v2 <= v1;
                if (v1) begin
                    s2_q <= s2_d;
                    t2   <= t1;
                end
            end
            if (ld3) begin
                v3 <= v2;
                if (v2) begin
                    r3 <= r3_d;
                    t3 <= t2;
                end
            end
        end
    end

    assign out_valid = v3;
    assign out_res   = r3;
    assign out_tag   = t3;

endmodule

// File: tb/tb_rns_residue_hp_pipe.sv
// Scoreboard bench: moduli 17, 13 and 11 run side by side on one stream.
module tb_rns_residue_hp_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] in_data;
    logic [3:0]  in_tag;
    logic        rdy17, rdy13, rdy11;
    logic        ov17, ov13, ov11;
    logic [4:0]  r17;
    logic [3:0]  r13, r11;
    logic [3:0]  t17, t13, t11;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0] tag;
        logic [4:0] e17;
        logic [3:0] e13;
        logic [3:0] e11;
        int         cyc;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    rns_residue_hp_pipe #(.N_W(16), .MOD(17), .HP(4), .TAG_W(4)) u17 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy17),
        .in_data(in_data), .in_tag(in_tag), .out_valid(ov17),
        .out_ready(out_ready), .out_res(r17), .out_tag(t17)
    );

    rns_residue_hp_pipe #(.N_W(16), .MOD(13), .HP(6), .TAG_W(4)) u13 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy13),
        .in_data(in_data), .in_tag(in_tag), .out_valid(ov13),
        .out_ready(out_ready), .out_res(r13), .out_tag(t13)
    );

    rns_residue_hp_pipe #(.N_W(16), .MOD(11), .HP(5), .TAG_W(4)) u11 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy11),
        .in_data(in_data), .in_tag(in_tag), .out_valid(ov11),
        .out_ready(out_ready), .out_res(r11), .out_tag(t11)
    );

    function automatic exp_t mk(input logic [15:0] x, input logic [3:0] tag,
                                input int cyc);
        exp_t m;
        m.tag = tag;
        m.e17 = 5'(int'(x) % 17);
        m.e13 = 4'(int'(x) % 13);
        m.e11 = 4'(int'(x) % 11);
        m.cyc = cyc;
        return m;
    endfunction

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        in_tag    = '0;
        @(negedge clk);
        #1;
        n_vec++;
        if ({ov17, ov13, ov11, r17, r13, r11, t17, t13, t11} !== 27'd0) begin
            n_err++;
            $display("FAIL reset_outputs got %h required 0",
                     {ov17, ov13, ov11, r17, r13, r11, t17, t13, t11});
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_vec++;
        if ({rdy17, rdy13, rdy11} !== 3'b111) begin
            n_err++;
            $display("FAIL reset_in_ready got %b required 111",
                     {rdy17, rdy13, rdy11});
        end
    endtask

    task automatic test_stream();
        logic [15:0] vec [6] = '{16'd0, 16'd16, 16'd17, 16'd1000, 16'd65535, 16'd12};
        int   pushed = 0;
        exp_t e;
        for (int it = 0; it < 40 && (pushed < 6 || sb.size() > 0); it++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = (pushed < 6);
            in_tag    = 4'(pushed);
            if (pushed < 6) in_data = vec[pushed];
            #1;
            if (ov17 && out_ready) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL stream_extra got tag %0d required none", t17);
                end else begin
                    e = sb.pop_front();
                    if ({ov13, ov11, r17, r13, r11, t17, t13, t11} !==
                        {2'b11, e.e17, e.e13, e.e11, e.tag, e.tag, e.tag}) begin
                        n_err++;
                        $display("FAIL stream_result got %0d/%0d/%0d tag %0d required %0d/%0d/%0d tag %0d",
                                 r17, r13, r11, t17, e.e17, e.e13, e.e11, e.tag);
                    end
                    n_vec++;
                    if (it - e.cyc !== 3) begin
                        n_err++;
                        $display("FAIL stream_latency got %0d required 3", it - e.cyc);
                    end
                end
            end
            if (in_valid && rdy17) begin
                sb.push_back(mk(in_data, in_tag, it));
                pushed++;
            end
        end
        in_valid = 1'b0;
        n_vec++;
        if (pushed != 6 || sb.size() != 0) begin
            n_err++;
            $display("FAIL stream_timeout got %0d pending required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_backpressure();
        int   pushed = 0;
        exp_t e;
        for (int it = 0; it < 8; it++) begin
            @(negedge clk);
            out_ready = 1'b0;
            in_valid  = (pushed < 5);
            in_tag    = 4'(pushed + 1);
            in_data   = 16'(100 * (pushed + 1) + 7);
            #1;
            n_vec++;
            if (rdy17 !== (sb.size() < 3)) begin
                n_err++;
                $display("FAIL bp_in_ready got %b required %b", rdy17, sb.size() < 3);
            end
            if (ov17 && sb.size() > 0) begin
                n_vec++;
                if ({r17, r13, r11, t17} !== {sb[0].e17, sb[0].e13, sb[0].e11, sb[0].tag}) begin
                    n_err++;
                    $display("FAIL bp_hold got %0d tag %0d required %0d tag %0d",
                             r17, t17, sb[0].e17, sb[0].tag);
                end
            end
            if (in_valid && rdy17) begin
                sb.push_back(mk(in_data, in_tag, it));
                pushed++;
            end
        end
        n_vec++;
        if (pushed != 3) begin
            n_err++;
            $display("FAIL bp_accepts got %0d required 3", pushed);
        end
        for (int it = 0; it < 40 && (pushed < 5 || sb.size() > 0); it++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = (pushed < 5);
            in_tag    = 4'(pushed + 1);
            in_data   = 16'(100 * (pushed + 1) + 7);
            #1;
            if (ov17 && out_ready) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL bp_extra got tag %0d required none", t17);
                end else begin
                    e = sb.pop_front();
                    if ({ov13, ov11, r17, r13, r11, t17, t13, t11} !==
                        {2'b11, e.e17, e.e13, e.e11, e.tag, e.tag, e.tag}) begin
                        n_err++;
                        $display("FAIL bp_drain got %0d tag %0d required %0d tag %0d",
                                 r17, t17, e.e17, e.tag);
                    end
                end
            end
            if (in_valid && rdy17) begin
                sb.push_back(mk(in_data, in_tag, it));
                pushed++;
            end
        end
        in_valid = 1'b0;
        n_vec++;
        if (pushed != 5 || sb.size() != 0) begin
            n_err++;
            $display("FAIL bp_timeout got %0d pending required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset_midstream();
        exp_t e;
        for (int it = 0; it < 3; it++) begin
            @(negedge clk);
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_data   = 16'(3000 + it);
            in_tag    = 4'(it + 5);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        n_vec++;
        if ({ov17, ov13, ov11, r17, t17} !== 12'd0) begin
            n_err++;
            $display("FAIL midrst_clear got %h required 0", {ov17, ov13, ov11, r17, t17});
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_vec++;
        if ({rdy17, ov17} !== 2'b10) begin
            n_err++;
            $display("FAIL midrst_release got %b required 10", {rdy17, ov17});
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'd17;
        in_tag    = 4'd9;
        e = mk(in_data, in_tag, 0);
        for (int it = 1; it <= 3; it++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            n_vec++;
            if (it < 3 && ov17 !== 1'b0) begin
                n_err++;
                $display("FAIL midrst_early got out_valid %b at %0d required 0", ov17, it);
            end else if (it == 3 && {ov17, r17, r13, r11, t17} !==
                         {1'b1, e.e17, e.e13, e.e11, e.tag}) begin
                n_err++;
                $display("FAIL midrst_first got %b %0d/%0d/%0d tag %0d required 1 %0d/%0d/%0d tag %0d",
                         ov17, r17, r13, r11, t17, e.e17, e.e13, e.e11, e.tag);
            end
        end
    endtask

    task automatic test_random();
        int   pushed  = 0;
        bit   pending = 0;
        bit   exp_rdy;
        exp_t e;
        for (int it = 0; it < 60000 && (pushed < 10000 || sb.size() > 0); it++) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 9) < 7);
            if (!pending) begin
                in_valid = (pushed < 10000) && ($urandom_range(0, 9) < 7);
                in_tag   = 4'(pushed);
                in_data  = ($urandom_range(0, 7) == 0) ? 16'hFFFF
                         : 16'($urandom_range(0, 65535));
            end
            #1;
            exp_rdy = !(sb.size() == 3 && !out_ready);
            n_vec++;
            if ({rdy17, rdy13, rdy11} !== {3{exp_rdy}}) begin
                n_err++;
                $display("FAIL rand_in_ready got %b required %b",
                         {rdy17, rdy13, rdy11}, {3{exp_rdy}});
            end
            if (ov17 && out_ready) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL rand_extra got tag %0d required none", t17);
                end else begin
                    e = sb.pop_front();
                    if ({ov13, ov11, r17, r13, r11, t17, t13, t11} !==
                        {2'b11, e.e17, e.e13, e.e11, e.tag, e.tag, e.tag}) begin
                        n_err++;
                        $display("FAIL rand_result got %0d/%0d/%0d tag %0d required %0d/%0d/%0d tag %0d",
                                 r17, r13, r11, t17, e.e17, e.e13, e.e11, e.tag);
                    end
                end
            end
            if (in_valid && rdy17) begin
                sb.push_back(mk(in_data, in_tag, it));
                pushed++;
                pending = 0;
            end else begin
                pending = in_valid;
            end
        end
        in_valid = 1'b0;
        n_vec++;
        if (pushed != 10000 || sb.size() != 0) begin
            n_err++;
            $display("FAIL rand_timeout got %0d sent %0d pending required 10000 sent 0 pending",
                     pushed, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_reset_midstream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rns_residue_hp_pipe.md
Name: rns_residue_hp_pipe

Overview:
- Pipelined, parametrised residue generator. Computes X mod MOD for an N_W-bit operand X.
- Works for any modulus with a half period HP, meaning 2^HP ≡ −1 (mod MOD).
- Method: two half-period fold stages, then an exact final correction. The output is the true residue in [0, MOD−1], not a partially reduced value.
- Sits in the binary-to-RNS forward converter, one instance per channel (e.g. 17, 13, 11). Uses valid/ready on both sides and passes a tag through so channels can be realigned.

Parameters:
- N_W, 16, input operand width.
- MOD, 17, modulus. Must be odd and > 2.
- HP, 4, half period, with 2^HP mod MOD == MOD−1. Examples: 17→4, 13→6, 11→5.
- TAG_W, 4, width of the sideband tag carried alongside each operand.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input operand valid.
- in_ready  out  1  block can accept an operand this cycle.
- in_data  in  N_W  operand X (unsigned).
- in_tag  in  TAG_W  sideband tag, returned unchanged with the result.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_res  out  R_W  X mod MOD, where R_W = clog2(MOD).
- out_tag  out  TAG_W  tag that arrived with this operand.

Behaviour:
- Reset (asynchronous, active-low):
  - All stage valid bits clear; all data and tag registers go to 0.
  - Outputs: out_valid=0, out_res=0, out_tag=0. in_ready=1 once rst_n is high.
- Pipeline: 3 register stages (S1, S2, S3). Latency from input handshake to out_valid is 3 cycles with no stall. Throughput is 1 result per cycle.
- Stall rules:
  - Stage k loads when it is empty or when its contents move on in the same cycle.
  - in_ready = !v1 | (!v2 | (!v3 | out_ready)).
  - A combinational path out_ready→in_ready is permitted.
  - Input accepted ⇔ in_valid & in_ready. Output taken ⇔ out_valid & out_ready.
- While out_valid=1 and out_ready=0, out_res and out_tag hold stable. No result is dropped or duplicated.
- Fold definition:
  - Split the value into HP-bit groups G_i, starting from the LSB; the top group is zero-extended.
  - Even-indexed groups are added as-is.
  - Odd-indexed groups are added as ~G_i, complemented over HP bits.
  - Add the constant 2·(number of odd groups).
  - This is valid because ~G ≡ −G−2 (mod MOD).
- S1: S1 = fold(X), width S1_W = HP + clog2(NG+1) + 1, where NG = ceil(N_W/HP).
  - Elaboration check: S1_W ≤ 2·HP, otherwise fatal error.
- S2: S2 = fold(S1), using exactly 2 groups. Bound S2 ≤ 2^(HP+1), width HP+2.
- S3: restoring reduction. For k = KB down to 0: if v ≥ MOD·2^k, v −= MOD·2^k. KB is the smallest k with MOD·2^(k+1) > 2^(HP+1).
  - Register the result as out_res, always in [0, MOD−1].
- Boundary values: X=0 → 0. X=MOD → 0. X = 2^N_W − 1 → exact residue. A value exactly equal to a multiple of MOD after S2 must reduce to 0.
- Reset asserted mid-stream: all in-flight operands are discarded, with no partial output afterwards. The first operand after release has latency 3.
- Tags travel in lock-step with their data through every stage.
- Elaboration check: 2^HP mod MOD == MOD−1, otherwise fatal error.

Decomposition:
- Package rns_pkg:
  - clog2 function.
  - Half-period check function.
  - Constants for the standard moduli set (MOD_17/HP_4, MOD_13/HP_6, MOD_11/HP_5).
  - Fold-offset function 2·floor(NG/2).
- Sub-module hp_fold: purely combinational, parameters IN_W and HP. Instantiated once for S1 and once for S2.
- The restoring correction and the handshake control stay in the top module.

Test Plan:
- MOD=17: stream X = 0, 16, 17, 1000, 65535 with out_ready=1 → out_res = 0, 16, 0, 14, 0 respectively, each 3 cycles after acceptance, one per cycle, tags 0..4 returned in order.
- MOD=13, HP=6: X=65535 → 2; X=1000 → 12; X=12 → 12. MOD=11, HP=5: X=65535 → 8; X=1000 → 10.
- Backpressure: fill with tags 1..5 and hold out_ready=0 → in_ready drops after 3 accepts; out_res and out_tag stay stable. Then release → remaining results drain in order with no loss or duplicate.
- Reset mid-stream: assert rst_n low with 3 operands in flight → out_valid=0 immediately. After release, a new X=17 → out_res=0, 3 cycles later.
- Random: 10k operands with random in_valid/out_ready, all three moduli → every out_res equals X % MOD against a scoreboard, and tag order is preserved.
